// File: rtl/ser_capture_pkg.sv
// Shared types and defaults for the serial word capture endpoint.
package ser_capture_pkg;

    localparam int unsigned W_DEF     = 8;
    localparam int unsigned DEPTH_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } fsm_state_e;

    // Default-width entry; modules with other widths declare the same layout locally.
    typedef struct packed {
        logic             partial;
        logic [W_DEF-1:0] data;
    } cap_entry_t;

endpackage

// File: rtl/sync_fifo_ptr.sv
// Single-clock FIFO with wrap-bit pointers; head entry is read combinationally.
module sync_fifo_ptr #(
    parameter int unsigned DW    = 9,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_rd;
    logic          do_wr;

    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        level   = wr_ptr - rd_ptr;
        do_rd   = rd_en && !empty;
        // A pop while full frees the slot the push lands in during the same edge.
        do_wr   = wr_en && (!full || do_rd);
        rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ser_word_capture.sv
// Assembles an LSB-first serial stream into W-bit words and queues them for a valid/ready consumer.
module ser_word_capture
    import ser_capture_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned CW   = $clog2(W),
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ser_data,
    input  logic          ser_valid,
    input  logic          ser_last,
    output logic [W-1:0]  par_data,
    output logic          par_partial,
    output logic          par_valid,
    input  logic          par_ready,
    output logic          overflow,
    input  logic          clr_ovf,
    output logic [AW:0]   level
);

    typedef struct packed {
        logic         partial;
        logic [W-1:0] data;
    } entry_t;

    fsm_state_e    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  shreg;
    logic [W-1:0]  word_next;
    logic          at_top;
    logic          done;
    entry_t        push_entry;
    entry_t        head_entry;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;

    always_comb begin
        word_next      = shreg;
        word_next[cnt] = ser_data;
        at_top         = (cnt == CW'(W - 1));
        done           = ser_valid && (at_top || ser_last);
        push_entry     = '{partial: ser_last && !at_top, data: word_next};
        pop            = par_ready && !fifo_empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            shreg    <= '0;
            overflow <= 1'b0;
        end else begin
            if (done) begin
                state <= IDLE;
                cnt   <= '0;
                shreg <= '0;
            end else if (ser_valid) begin
                state <= SHIFT;
                cnt   <= cnt + 1'b1;
                shreg <= word_next;
            end
            // Set takes priority over clear.
            if (done && fifo_full && !pop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    sync_fifo_ptr #(
        .DW    (W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (done),
        .wr_data (push_entry),
        .rd_en   (par_ready),
        .rd_data (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign par_data    = head_entry.data;
    assign par_partial = head_entry.partial;
    assign par_valid   = !fifo_empty;

endmodule
